// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level open-drain I2C master.
// Produces START, repeated START and STOP. Sends and receives bytes MSB first.
// Ports:
//   clk, reset    : clock and asynchronous active-high reset
//   start         : active-low request
//   send, receive : command levels from the sequencer
//   datasend      : byte to transmit
//   sended        : asserted while the master waits for the next command
//   datareceive   : last byte read from the slave
//   received      : strobe marking a newly read byte
//   sda_in        : SDA pin level
//   sda_oe/scl_oe : 1 pulls the pin low, 0 releases it
//   busy, ack_err, state_out : status outputs
module i2c_byte_master #(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       send,
  input  logic [7:0] datasend,
  output logic       sended,
  input  logic       receive,
  output logic [7:0] datareceive,
  output logic       received,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic       busy,
  output logic       ack_err,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START   = 4'd1,
    S_WRITE   = 4'd2,
    S_WACK    = 4'd3,
    S_DECIDE  = 4'd4,
    S_RESTART = 4'd5,
    S_READ    = 4'd6,
    S_RACK    = 4'd7,
    S_STOP    = 4'd8
  } state_t;

  localparam logic [7:0] QMAX = 8'(CLK_DIV - 1);
  localparam logic [7:0] RLEN = 8'(CLK_DIV);

  state_t     state, nxt;
  logic [7:0] qcnt;
  logic [1:0] tcnt;
  logic [1:0] fin;
  logic [2:0] bcnt;
  logic [7:0] sreg;
  logic [7:0] rcnt;
  logic       rw;
  logic       nack;
  logic       ackr;
  logic       sda_m;
  logic       sda_s;
  logic       start_q;
  logic       tend;
  logic       last;
  logic       bit_lo;
  logic       accept;
  logic       load;
  logic       bit_end;
  logic       cap;

  // tend: final clk of a tick; last: final clk of the state
  assign tend    = (qcnt == QMAX);
  assign last    = tend && (tcnt == fin);
  assign bit_lo  = (tcnt == 2'd0) || (tcnt == 2'd3);
  // Falling edge of start: a long low level is one request
  assign accept  = (state == S_IDLE) && !start && start_q;
  assign bit_end = (state == S_WRITE || state == S_READ)
                   && tend && (tcnt == 2'd3);
  assign cap     = (state == S_READ) && tend
                   && (tcnt == 2'd1) && (bcnt == 3'd0);

  assign busy      = (state != S_IDLE);
  assign state_out = state;

  always_comb begin
    fin = 2'd3;
    unique case (state)
      S_START, S_STOP: fin = 2'd2;
      S_DECIDE:        fin = 2'd1;
      default:         fin = 2'd3;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt    = state;
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    sended = 1'b0;
    load   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) nxt = S_START;
      end
      S_START: begin
        sda_oe = 1'b1;
        scl_oe = (tcnt == 2'd2);
        if (last) begin
          load = 1'b1;
          nxt  = S_WRITE;
        end
      end
      S_WRITE: begin
        sda_oe = ~sreg[7];
        scl_oe = bit_lo;
        if (last && bcnt == 3'd0) nxt = S_WACK;
      end
      S_WACK: begin
        scl_oe = bit_lo;
        if (last) begin
          if (nack)    nxt = S_STOP;
          else if (rw) nxt = S_READ;
          else         nxt = S_DECIDE;
        end
      end
      S_DECIDE: begin
        scl_oe = 1'b1;
        sended = 1'b1;
        if (last) begin
          if (send) begin
            load = 1'b1;
            nxt  = S_WRITE;
          end else if (receive) begin
            nxt = S_RESTART;
          end else begin
            nxt = S_STOP;
          end
        end
      end
      S_RESTART: begin
        sda_oe = (tcnt != 2'd0);
        scl_oe = (tcnt == 2'd3);
        if (last) begin
          load = 1'b1;
          nxt  = S_WRITE;
        end
      end
      S_READ: begin
        scl_oe = bit_lo;
        if (last && bcnt == 3'd0) nxt = S_RACK;
      end
      S_RACK: begin
        sda_oe = ackr;
        scl_oe = bit_lo;
        if (last) nxt = ackr ? S_READ : S_STOP;
      end
      S_STOP: begin
        sda_oe = (tcnt != 2'd2);
        scl_oe = (tcnt == 2'd0);
        if (last) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qcnt        <= '0;
      tcnt        <= '0;
      bcnt        <= 3'd7;
      sreg        <= '0;
      rcnt        <= '0;
      rw          <= 1'b0;
      nack        <= 1'b0;
      ackr        <= 1'b0;
      sda_m       <= 1'b0;
      sda_s       <= 1'b0;
      start_q     <= 1'b0;
      ack_err     <= 1'b0;
      datareceive <= '0;
      received    <= 1'b0;
    end else begin
      sda_m   <= sda_in;
      sda_s   <= sda_m;
      start_q <= start;
      if (state == S_IDLE) begin
        qcnt <= '0;
        tcnt <= '0;
        bcnt <= 3'd7;
      end else if (tend) begin
        qcnt <= '0;
        tcnt <= last ? 2'd0 : tcnt + 2'd1;
      end else begin
        qcnt <= qcnt + 8'd1;
      end
      if (bit_end) bcnt <= (bcnt == 3'd0) ? 3'd7 : bcnt - 3'd1;
      if (accept)
        ack_err <= 1'b0;
      else if (state == S_WACK && last && nack)
        ack_err <= 1'b1;
      if (load) begin
        sreg <= datasend;
        rw   <= datasend[0];
      end else if (state == S_WRITE && tend && tcnt == 2'd3) begin
        sreg <= {sreg[6:0], 1'b0};
      end else if (state == S_READ && tend && tcnt == 2'd1) begin
        sreg <= {sreg[6:0], sda_s};
      end
      if (state == S_WACK && tend && tcnt == 2'd1) nack <= sda_s;
      if (state == S_RACK && qcnt == 8'd0 && tcnt == 2'd0)
        ackr <= receive;
      if (cap) datareceive <= {sreg[6:0], sda_s};
      // received follows the capture by one clk and lasts one tick
      if (cap)              rcnt <= RLEN;
      else if (rcnt != 8'd0) rcnt <= rcnt - 8'd1;
      received <= (rcnt != 8'd0);
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: I2C slave model, bus monitor and scoreboard
// driving i2c_byte_master through write, read, NACK and reset cases.
module tb_i2c_byte_master;

  localparam int DIV = 4;
  localparam logic [15:0] EV_S = 16'h1000;
  localparam logic [15:0] EV_P = 16'h2000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       send;
  logic       receive;
  logic [7:0] datasend;
  logic [7:0] datareceive;
  logic       sended;
  logic       received;
  logic       sda_oe;
  logic       scl_oe;
  logic       busy;
  logic       ack_err;
  logic [3:0] state_out;
  logic       slv_sda = 1'b1;
  logic       sda_bus;
  logic       scl_bus;

  assign sda_bus = !sda_oe && slv_sda;
  assign scl_bus = !scl_oe;

  always #5 clk = ~clk;

  i2c_byte_master #(.CLK_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .send       (send),
    .datasend   (datasend),
    .sended     (sended),
    .receive    (receive),
    .datareceive(datareceive),
    .received   (received),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .scl_oe     (scl_oe),
    .busy       (busy),
    .ack_err    (ack_err),
    .state_out  (state_out)
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] evq[$];
  logic [7:0]  rxq[$];
  logic [7:0]  slv_rdq[$];
  logic [7:0]  wq[$];
  logic [7:0]  rq[$];
  logic        mon_en = 1'b0;
  logic        slv_nack = 1'b0;
  logic        pscl = 1'b1;
  logic        psda = 1'b1;
  logic        reading = 1'b0;
  logic [7:0]  shr = '0;
  logic [7:0]  rdb = '0;
  int          bitn = 0;
  int          byten = 0;
  int          cyc = 0;
  int          lastrise = 0;
  int          swid = 0;
  int          rwid = 0;
  int          nsended = 0;
  int          nrx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic ev(input logic [15:0] code);
    if (evq.size() == 0) chk("bus_unexp", 32'(code), 32'hFFFF_FFFF);
    else chk("bus_seq", 32'(code), 32'(evq.pop_front()));
  endtask

  function automatic logic [7:0] next_rd();
    if (slv_rdq.size() == 0) return 8'hFF;
    return slv_rdq.pop_front();
  endfunction

  always @(negedge clk) begin
    logic s_now;
    logic d_now;
    s_now = scl_bus;
    d_now = sda_bus;
    if (mon_en) begin
      if (s_now && pscl && psda && !d_now) begin
        ev(EV_S);
        bitn = 0; byten = 0; reading = 1'b0; slv_sda = 1'b1;
      end else if (s_now && pscl && !psda && d_now) begin
        ev(EV_P);
        bitn = 0; byten = 0; reading = 1'b0; slv_sda = 1'b1;
      end else if (s_now && !pscl) begin
        if (bitn > 0) chk("scl_period", 32'(cyc - lastrise), 32'(4 * DIV));
        lastrise = cyc;
        if (bitn < 8) begin
          shr = {shr[6:0], d_now};
          bitn++;
        end else begin
          ev({7'd0, d_now, shr});
          if (reading) begin
            if (!d_now) rdb = next_rd();
            else        reading = 1'b0;
          end else if (byten == 0 && shr[0] && !d_now) begin
            reading = 1'b1;
            rdb = next_rd();
          end
          bitn = 0;
          byten++;
        end
      end else if (!s_now && pscl) begin
        if (reading) slv_sda = (bitn < 8) ? rdb[7 - bitn] : 1'b1;
        else         slv_sda = (bitn == 8) ? slv_nack : 1'b1;
      end
      if (sended) begin
        swid++;
      end else if (swid != 0) begin
        chk("sended_width", 32'(swid), 32'(2 * DIV));
        nsended++;
        swid = 0;
      end
      if (received) begin
        if (rwid == 0) begin
          if (rxq.size() == 0)
            chk("rx_unexp", 32'(datareceive), 32'hFFFF_FFFF);
          else
            chk("rx_data", 32'(datareceive), 32'(rxq.pop_front()));
          nrx++;
        end
        rwid++;
      end else if (rwid != 0) begin
        chk("rx_width", 32'(rwid), 32'(DIV));
        rwid = 0;
      end
    end
    pscl = s_now;
    psda = d_now;
  end

  task automatic wait_for(input int sel, input logic lvl, input string tag);
    logic v;
    v = ~lvl;
    for (int i = 0; i < 4000; i++) begin
      v = (sel == 0) ? sended : busy;
      if (v == lvl) break;
      @(negedge clk);
    end
    chk(tag, 32'(v), 32'(lvl));
  endtask

  task automatic txn(input logic [7:0] addr, input logic nack,
                     input logic rd, input logic hold, input string nm);
    int ns0;
    int tgt;
    ns0 = nsended;
    tgt = nrx;
    evq.push_back(EV_S);
    evq.push_back({7'd0, nack, addr});
    if (!nack) begin
      foreach (wq[i]) evq.push_back({8'd0, wq[i]});
      if (rd) begin
        evq.push_back(EV_S);
        evq.push_back({8'd0, addr | 8'h01});
        foreach (rq[i]) begin
          evq.push_back({7'd0, (i == rq.size() - 1), rq[i]});
          rxq.push_back(rq[i]);
          slv_rdq.push_back(rq[i]);
        end
        tgt = nrx + rq.size();
      end
    end
    evq.push_back(EV_P);
    slv_nack = nack;
    datasend = addr;
    start = 1'b0;
    repeat (4) @(negedge clk);
    if (!hold) start = 1'b1;
    chk({nm, "_ackclr"}, 32'(ack_err), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    if (!nack) begin
      foreach (wq[i]) begin
        wait_for(0, 1'b1, {nm, "_sended_hi"});
        datasend = wq[i];
        send = 1'b1;
        wait_for(0, 1'b0, {nm, "_sended_lo"});
        send = 1'b0;
        datasend = 8'h00;
      end
      wait_for(0, 1'b1, {nm, "_sended_hi"});
      if (rd) begin
        datasend = addr | 8'h01;
        receive = 1'b1;
      end
      wait_for(0, 1'b0, {nm, "_sended_lo"});
      if (rd) begin
        for (int i = 0; i < 4000 && nrx < tgt; i++) @(negedge clk);
        receive = 1'b0;
        chk({nm, "_rx_count"}, 32'(nrx), 32'(tgt));
      end
    end
    wait_for(1, 1'b0, {nm, "_idle"});
    repeat (2) @(negedge clk);
    chk({nm, "_ack_err"}, 32'(ack_err), 32'(nack));
    chk({nm, "_sended_n"}, 32'(nsended - ns0),
        nack ? 32'd0 : 32'(1 + wq.size()));
    chk({nm, "_sb_left"}, 32'(evq.size()), 32'd0);
    chk({nm, "_rx_left"}, 32'(rxq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    reset = 1'b1;
    start = 1'b1;
    send = 1'b0;
    receive = 1'b0;
    datasend = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_scl_oe", 32'(scl_oe), 32'd0);
    chk("rst_sended", 32'(sended), 32'd0);
    chk("rst_received", 32'(received), 32'd0);
    chk("rst_datareceive", 32'(datareceive), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    datasend = 8'hEE;
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (state_out == 4'd2 && scl_oe && sda_oe) break;
      @(negedge clk);
    end
    chk("midwr_state", 32'(state_out), 32'd2);
    chk("midwr_lines", 32'({scl_oe, sda_oe}), 32'd3);
    reset = 1'b1;
    #1;
    chk("midwr_rst_scl", 32'(scl_oe), 32'd0);
    chk("midwr_rst_sda", 32'(sda_oe), 32'd0);
    chk("midwr_rst_busy", 32'(busy), 32'd0);
    chk("midwr_rst_state", 32'(state_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    wq.delete(); wq.push_back(8'hD0);
    rq.delete();
    txn(8'hEE, 1'b0, 1'b0, 1'b0, "wr2");

    wq.delete(); wq.push_back(8'hD0);
    rq.delete(); rq.push_back(8'h55);
    txn(8'hEE, 1'b0, 1'b1, 1'b0, "id_rd");

    wq.delete(); wq.push_back(8'hF6);
    rq.delete();
    rq.push_back(8'h12); rq.push_back(8'h34); rq.push_back(8'h56);
    txn(8'hEE, 1'b0, 1'b1, 1'b0, "multi_rd");
    chk("multi_last", 32'(datareceive), 32'h56);

    wq.delete();
    rq.delete();
    txn(8'hEE, 1'b1, 1'b0, 1'b0, "nack");

    wq.delete(); wq.push_back(8'hD0);
    rq.delete();
    txn(8'hEE, 1'b0, 1'b0, 1'b1, "hold");
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("hold_one_txn", 32'(nb), 32'd0);
    start = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
